// File: rtl/cmp_seq_ctrl.sv
// Multi-cycle magnitude comparator: one 4-bit slice comparator is stepped MSB-first over the operands.
// Optional macro CMP_SEQ_EARLY_EXIT_EN ends the scan at the first unequal slice.
module cmp_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lesser,
  output logic             greater,
  output logic             equal,
  output logic [1:0]       dbg_state
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: start is sampled only in IDLE or DONE; an accepted start captures a/b on that edge.
  // busy is high for every RUN cycle, done pulses for one cycle and flags are valid from then on.
  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx;
  logic             dec_valid, dec_gt;
  logic [3:0]       sa, sb;
  logic             s_ne, s_gt, last, finish, load;

  assign sa   = a_q[4*idx +: 4];
  assign sb   = b_q[4*idx +: 4];
  assign s_ne = (sa != sb);
  assign s_gt = (sa > sb);
  assign last = (idx == '0);

`ifdef CMP_SEQ_EARLY_EXIT_EN
  assign finish = s_ne | last;
`else
  assign finish = last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = RUN;
        load    = 1'b1;
      end
      RUN: if (finish) state_n = DONE;
      DONE: begin
        if (start) begin
          state_n = RUN;
          load    = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The first unequal slice wins; the visible flags change only on the edge that leaves RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      idx       <= '0;
      dec_valid <= 1'b0;
      dec_gt    <= 1'b0;
      lesser    <= 1'b0;
      greater   <= 1'b0;
      equal     <= 1'b0;
    end else if (load) begin
      a_q       <= a;
      b_q       <= b;
      idx       <= IDX_TOP;
      dec_valid <= 1'b0;
      dec_gt    <= 1'b0;
    end else if (state == RUN) begin
      if (s_ne && !dec_valid) begin
        dec_valid <= 1'b1;
        dec_gt    <= s_gt;
      end
      if (finish) begin
        if (dec_valid) begin
          lesser  <= ~dec_gt;
          greater <= dec_gt;
          equal   <= 1'b0;
        end else if (s_ne) begin
          lesser  <= ~s_gt;
          greater <= s_gt;
          equal   <= 1'b0;
        end else begin
          lesser  <= 1'b0;
          greater <= 1'b0;
          equal   <= 1'b1;
        end
      end else begin
        idx <= idx - 1'b1;
      end
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;
endmodule
